// File: rtl/zcyc_pkg.sv
// Shared encodings for the fclk cycle timer: one-hot phase strobes and stall FSM states.
package zcyc_pkg;

    localparam logic [3:0] PH_NONE = 4'b0000;
    localparam logic [3:0] PH_CBEG = 4'b0001;
    localparam logic [3:0] PH_POST = 4'b0010;
    localparam logic [3:0] PH_PRE  = 4'b0100;
    localparam logic [3:0] PH_CEND = 4'b1000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_GAP   = 2'd2
    } stall_st_e;

endpackage

// File: rtl/zstall_ctl.sv
// Z80 clock freeze controller; all decisions are taken only on cycle-start edges.
// state | meaning
// RUN   | clock running, waiting for a request at a cycle start
// STALL | clock frozen, counting consecutive stalled cycles
// GAP   | one forced running cycle after the watchdog released a stall
module zstall_ctl
    import zcyc_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 255
) (
    input  logic fclk,
    input  logic rst,
    input  logic cs,
    input  logic stall_req,
    output logic zclk_stall,
    output logic stall_to
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stall_st_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;
    logic             to_q, to_d;

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        to_d    = 1'b0;
        if (cs) begin
            case (state_q)
                ST_STALL: begin
                    if (!stall_req) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        stall_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                        stall_d = 1'b0;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        stall_d = 1'b1;
                    end
                end
                // GAP re-arms exactly like RUN at the following cycle start
                default: begin
                    if (stall_req) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_ONE;
                        stall_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        stall_d = 1'b0;
                    end
                end
            endcase
        end
    end

    assign zclk_stall = stall_q;
    assign stall_to   = to_q;

endmodule

// File: rtl/zcyc_gen.sv
// Master 4-phase fclk cycle timer with half-rate marker and whole-cycle Z80 stall control.
module zcyc_gen
    import zcyc_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 255
) (
    input  logic fclk,
    input  logic rst,
    input  logic sync,
    input  logic stall_req,
    output logic cbeg,
    output logic post_cbeg,
    output logic pre_cend,
    output logic cend,
    output logic hcyc,
    output logic zclk_stall,
    output logic stall_to
);

    logic [3:0] phase_q, phase_d;
    logic       hcyc_q, hcyc_d;
    logic       restart_pend;
    logic       cs;

    // An all-zero phase register is the post-reset "restart pending" state
    assign restart_pend = (phase_q == PH_NONE);
    assign cs           = restart_pend | phase_q[3] | sync;

    always_comb begin
        phase_d = cs ? PH_CBEG : {phase_q[2:0], 1'b0};
        hcyc_d  = (cs && !restart_pend) ? ~hcyc_q : hcyc_q;
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            phase_q <= PH_NONE;
            hcyc_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hcyc_q  <= hcyc_d;
        end
    end

    zstall_ctl #(
        .CNT_W     (CNT_W),
        .STALL_MAX (STALL_MAX)
    ) u_stall (
        .fclk       (fclk),
        .rst        (rst),
        .cs         (cs),
        .stall_req  (stall_req),
        .zclk_stall (zclk_stall),
        .stall_to   (stall_to)
    );

    assign cbeg      = phase_q[0];
    assign post_cbeg = phase_q[1];
    assign pre_cend  = phase_q[2];
    assign cend      = phase_q[3];
    assign hcyc      = hcyc_q;

endmodule

// File: tb/tb_zcyc_gen.sv
// Scoreboard bench for zcyc_gen: directed edge-by-edge expectations plus random invariant sweep.
module tb_zcyc_gen;
    import zcyc_pkg::*;

    localparam int SMAX = 3;

    logic fclk = 1'b0;
    logic rst = 1'b1;
    logic sync = 1'b0;
    logic stall_req = 1'b0;
    logic cbeg, post_cbeg, pre_cend, cend, hcyc, zclk_stall, stall_to;

    zcyc_gen #(.CNT_W(8), .STALL_MAX(SMAX)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .sync       (sync),
        .stall_req  (stall_req),
        .cbeg       (cbeg),
        .post_cbeg  (post_cbeg),
        .pre_cend   (pre_cend),
        .cend       (cend),
        .hcyc       (hcyc),
        .zclk_stall (zclk_stall),
        .stall_to   (stall_to)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic [3:0] ph;
        logic       h;
        logic       z;
        logic       t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   edge_no = 0;
    bit   rand_en = 1'b0;
    logic prev_z = 1'b0;
    int   run_len = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s edge=%0d: got %h, want %h", nm, edge_no, act, want);
        end
    endtask

    // Drive inputs for the next edge and queue what that edge must produce
    task automatic step(input logic r, input logic s, input logic q,
                        input logic [3:0] ph, input logic h, input logic z, input logic t);
        exp_t x;
        @(negedge fclk);
        rst = r;
        sync = s;
        stall_req = q;
        x.ph = ph;
        x.h  = h;
        x.z  = z;
        x.t  = t;
        sb.push_back(x);
    endtask

    task automatic cyc(input logic q0, input logic qr, input logic h, input logic z, input logic t);
        step(1'b0, 1'b0, q0, PH_CBEG, h, z, t);
        step(1'b0, 1'b0, qr, PH_POST, h, z, 1'b0);
        step(1'b0, 1'b0, qr, PH_PRE,  h, z, 1'b0);
        step(1'b0, 1'b0, qr, PH_CEND, h, z, 1'b0);
    endtask

    always @(posedge fclk) begin
        #2;
        if (sb.size() > 0) begin
            edge_no++;
            e = sb.pop_front();
            chk("phase", {cend, pre_cend, post_cbeg, cbeg}, e.ph);
            chk("hcyc", {3'b0, hcyc}, {3'b0, e.h});
            chk("zclk_stall", {3'b0, zclk_stall}, {3'b0, e.z});
            chk("stall_to", {3'b0, stall_to}, {3'b0, e.t});
        end
    end

    always @(posedge fclk) begin
        #2;
        if (rand_en) begin
            chk("rnd_onehot", 4'($countones({cend, pre_cend, post_cbeg, cbeg})), 4'd1);
            if (zclk_stall !== prev_z)
                chk("rnd_stall_mid", {3'b0, cbeg}, 4'd1);
            if (stall_to)
                chk("rnd_to_cbeg", {3'b0, cbeg}, 4'd1);
            if (cbeg) begin
                run_len = zclk_stall ? run_len + 1 : 0;
                chk("rnd_run_len", {3'b0, run_len <= SMAX}, 4'd1);
            end
        end
        prev_z = zclk_stall;
    end

    initial begin
        // reset
        step(1, 0, 0, PH_NONE, 0, 0, 0);
        step(1, 0, 0, PH_NONE, 0, 0, 0);
        // edges 1-8: release and free-running rotation
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // edges 9-28: request from post_cbeg of N, dropped inside N+3
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        // edges 29-60: held request, watchdog release and re-entry
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 1);
        // edges 61-72: sync on post_cbeg aborts; sync on cend is a no-op
        step(0, 0, 0, PH_CBEG, 1, 0, 0);
        step(0, 0, 0, PH_POST, 1, 0, 0);
        step(0, 1, 0, PH_CBEG, 0, 0, 0);
        step(0, 0, 0, PH_POST, 0, 0, 0);
        step(0, 0, 0, PH_PRE,  0, 0, 0);
        step(0, 0, 0, PH_CEND, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        step(0, 1, 0, PH_CBEG, 0, 0, 0);
        step(0, 0, 0, PH_POST, 0, 0, 0);
        // edges 73-100: reset in the 2nd stalled cycle, counter restarts at 1
        step(0, 0, 1, PH_PRE,  0, 0, 0);
        step(0, 0, 1, PH_CEND, 0, 0, 0);
        cyc(1, 1, 1, 1, 0);
        step(0, 0, 1, PH_CBEG, 0, 1, 0);
        step(1, 0, 1, PH_NONE, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // edges 101-108: back-to-back sync cycles each count as a stalled cycle
        step(0, 0, 1, PH_CBEG, 1, 1, 0);
        step(0, 1, 1, PH_CBEG, 0, 1, 0);
        step(0, 1, 1, PH_CBEG, 1, 1, 0);
        step(0, 1, 1, PH_CBEG, 0, 0, 1);
        step(0, 0, 0, PH_POST, 0, 0, 0);
        step(0, 0, 0, PH_PRE,  0, 0, 0);
        step(0, 0, 0, PH_CEND, 0, 0, 0);
        step(0, 0, 0, PH_CBEG, 1, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge fclk);
        #4;
        chk("drain", 4'(sb.size()), 4'd0);

        @(negedge fclk);
        sync = 1'b0;
        stall_req = 1'b0;
        rand_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge fclk);
            sync = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) stall_req = ~stall_req;
        end
        @(negedge fclk);
        rand_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
